// File: rtl/dacif_pkg.sv
// Shared definitions for the dacif_tdm serial DAC transmitter: framing modes,
// frame-length rule and slot bit indexing.
package dacif_pkg;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_LJ  = 1'b1
  } mode_e;

  // Serial bits per frame.
  function automatic int frame_bits(input int channels, input int slot_bits);
    return channels * slot_bits;
  endfunction

  // Position inside the current slot (0 = slot MSB) for a frame bit index.
  function automatic int slot_bit(input int bit_cnt, input int slot_bits);
    return bit_cnt % slot_bits;
  endfunction

endpackage

// File: rtl/dacif_tdm_clkgen.sv
// Bit-clock generator for dacif_tdm: BCK divider, fall strobe, frame bit counter
// and the frame-load (wrap) strobe.
module dacif_tdm_clkgen #(
  parameter int BCK_DIV = 1,
  parameter int N       = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 bck,
  output logic                 fall,
  output logic                 wrap,
  output logic [$clog2(N)-1:0] bit_cnt
);

  localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int BIT_W = $clog2(N);

  logic [DIV_W-1:0] div_reg;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic             bck_reg;
  logic             started_reg;
  logic             tc;

  assign tc   = (div_reg == DIV_W'(BCK_DIV - 1));
  assign fall = en && tc && bck_reg;
  // The first fall after enable starts a frame without waiting for a wrap.
  assign wrap = fall && (!started_reg || (bit_cnt_reg == BIT_W'(N - 1)));

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_reg     <= '0;
      bit_cnt_reg <= '0;
      bck_reg     <= 1'b0;
      started_reg <= 1'b0;
    end else if (tc) begin
      div_reg <= '0;
      bck_reg <= ~bck_reg;
      if (bck_reg) begin
        started_reg <= 1'b1;
        bit_cnt_reg <= wrap ? '0 : bit_cnt_reg + BIT_W'(1);
      end
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  assign bck     = bck_reg;
  assign bit_cnt = bit_cnt_reg;

endmodule

// File: rtl/dacif_tdm.sv
// Multi-channel I2S / left-justified TDM transmitter with a one-frame input buffer.
// Optional DACIF_TDM_HOLD_EN: underruns replay the last good frame instead of silence.
module dacif_tdm
  import dacif_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int SLOT_BITS = 32,
  parameter int CHANNELS  = 2,
  parameter int BCK_DIV   = 1,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         mode_lj,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHANNELS*DATA_W-1:0]   s_data,
  output logic                         frame_start,
  output logic                         underrun,
  output logic [CNT_W-1:0]             underrun_cnt,
  output logic                         dac_bck,
  output logic                         dac_fs,
  output logic                         dac_data
);

  localparam int N    = frame_bits(CHANNELS, SLOT_BITS);
  localparam int BC_W = $clog2(N);
  localparam int SW   = CHANNELS * DATA_W;

  logic            bck;
  logic            fall;
  logic            wrap;
  logic [BC_W-1:0] bit_cnt;

  dacif_tdm_clkgen #(
    .BCK_DIV (BCK_DIV),
    .N       (N)
  ) u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .bck     (bck),
    .fall    (fall),
    .wrap    (wrap),
    .bit_cnt (bit_cnt)
  );

  logic [SW-1:0]  buf_reg;
  logic [SW-1:0]  src;
  logic           full_reg;
  logic [N:0]     sh_reg;
  logic [N-1:0]   frame;
  mode_e          mode_reg;
  logic           fs_reg;
  logic           start_reg;
  logic           under_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic           xfer;

  assign xfer = s_valid && !full_reg;

`ifdef DACIF_TDM_HOLD_EN
  logic [SW-1:0] hold_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg <= '0;
    end else if (en && wrap && full_reg) begin
      hold_reg <= buf_reg;
    end
  end

  assign src = full_reg ? buf_reg : hold_reg;
`else
  assign src = full_reg ? buf_reg : '0;
`endif

  // frame[N-1] is the first bit on the wire (slot 0 MSB); pad bits below each LSB.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_fmt
      if (slot_bit(N - 1 - gi, SLOT_BITS) < DATA_W) begin : g_data
        assign frame[gi] = src[((N - 1 - gi) / SLOT_BITS) * DATA_W + DATA_W - 1
                               - slot_bit(N - 1 - gi, SLOT_BITS)];
      end else begin : g_pad
        assign frame[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_reg   <= '0;
      full_reg  <= 1'b0;
      sh_reg    <= '0;
      fs_reg    <= 1'b0;
      mode_reg  <= MODE_I2S;
      start_reg <= 1'b0;
      under_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      start_reg <= 1'b0;
      under_reg <= 1'b0;
      if (xfer) begin
        buf_reg  <= s_data;
        full_reg <= 1'b1;
      end
      if (!en) begin
        sh_reg <= '0;
        fs_reg <= 1'b0;
      end else if (wrap) begin
        mode_reg  <= mode_e'(mode_lj);
        fs_reg    <= mode_lj;
        start_reg <= 1'b1;
        if (full_reg) begin
          full_reg <= 1'b0;
        end else begin
          under_reg <= 1'b1;
          if (cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
        end
        // Spare shifter bit carries the frame's last bit so I2S can emit it one BCK late.
        if (mode_e'(mode_lj) == MODE_LJ) sh_reg <= {frame, frame[0]};
        else                             sh_reg <= {sh_reg[N-1], frame};
      end else if (fall) begin
        sh_reg <= {sh_reg[N-1:0], 1'b0};
        if (bit_cnt == BC_W'(N / 2 - 1)) fs_reg <= (mode_reg != MODE_LJ);
      end
    end
  end

  assign s_ready      = ~full_reg;
  assign frame_start  = start_reg;
  assign underrun     = under_reg;
  assign underrun_cnt = cnt_reg;
  assign dac_bck      = bck;
  assign dac_fs       = fs_reg;
  assign dac_data     = sh_reg[N];

endmodule

// File: tb/tb_dacif_tdm.sv
// Self-checking bench for dacif_tdm (4-channel TDM, BCK_DIV=2): directed frame table,
// hand-written corner sequences and a cycle-level reference model under random stimulus.
module tb_dacif_tdm;

  localparam int DATA_W    = 24;
  localparam int SLOT_BITS = 32;
  localparam int CHANNELS  = 4;
  localparam int BCK_DIV   = 2;
  localparam int CNT_W     = 3;
  localparam int N         = CHANNELS * SLOT_BITS;
  localparam int SW        = CHANNELS * DATA_W;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int FRAME_CLK = N * 2 * BCK_DIV;

  logic             clk = 1'b0;
  logic             rst, en, mode_lj, s_valid;
  logic [SW-1:0]    s_data;
  logic             s_ready, frame_start, underrun, dac_bck, dac_fs, dac_data;
  logic [CNT_W-1:0] underrun_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit            m_full;
  logic [SW-1:0] m_buf, m_hold, m_cur;
  bit            m_lj, m_prev_last;
  int            m_cnt, m_t, m_fr;
  logic [N-1:0]  obs [4];

  typedef struct {
    logic [SW-1:0] data;
    logic          lj;
    logic [N-1:0]  exp;
  } vec_t;
  vec_t tbl [3];

  dacif_tdm #(
    .DATA_W    (DATA_W),
    .SLOT_BITS (SLOT_BITS),
    .CHANNELS  (CHANNELS),
    .BCK_DIV   (BCK_DIV),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode_lj      (mode_lj),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .frame_start  (frame_start),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .dac_bck      (dac_bck),
    .dac_fs       (dac_fs),
    .dac_data     (dac_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, required %0h", name, $time, got, want);
    end
  endtask

  // Frame bit p (0 = first on the wire) of a sample set.
  function automatic logic bit_of(input logic [SW-1:0] d, input int p);
    int c = p / SLOT_BITS;
    int j = p % SLOT_BITS;
    if (j >= DATA_W) return 1'b0;
    return d[c * DATA_W + DATA_W - 1 - j];
  endfunction

  function automatic bit next_is_load();
    int t2   = m_t + 1;
    int tog2 = (t2 + 1) / BCK_DIV;
    int f2   = tog2 / 2;
    return en && ((t2 + 1) % BCK_DIV == 0) && (tog2 % 2 == 0) && (tog2 > 0) && ((f2 - 1) % N == 0);
  endfunction

  task automatic rand_data();
    for (int c = 0; c < CHANNELS; c++) s_data[c * DATA_W +: DATA_W] = DATA_W'($urandom);
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare all outputs.
  task automatic step();
    bit   ld = 0, ur = 0, xfer = 0, fall_now = 0;
    int   tog = 0, f = 0, k = 0, fr = 0;
    logic e_fs = 0, e_data = 0;
    @(posedge clk);
    #1;
    if (rst) begin
      m_full = 0; m_buf = '0; m_hold = '0; m_cur = '0; m_lj = 0;
      m_prev_last = 0; m_cnt = 0; m_t = -1; m_fr = 0;
    end else begin
      xfer = s_valid && !m_full;
      if (!en) begin
        m_t = -1;
      end else begin
        m_t++;
        tog = (m_t + 1) / BCK_DIV;
        f = tog / 2;
        fall_now = ((m_t + 1) % BCK_DIV == 0) && (tog % 2 == 0) && (tog > 0);
        if (f > 0) k = (f - 1) % N;
        ld = fall_now && (k == 0);
      end
      if (ld) begin
        m_prev_last = (f == 1) ? 1'b0 : bit_of(m_cur, N - 1);
        m_lj = mode_lj;
        m_fr = (f - 1) / N;
        if (m_full) begin
          m_cur = m_buf;
          m_hold = m_buf;
        end else begin
          ur = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
`ifdef DACIF_TDM_HOLD_EN
          m_cur = m_hold;
`else
          m_cur = '0;
`endif
        end
        m_full = 0;
        $display("load  @%0t frame=%0d lj=%0d underrun=%0d samples=%h", $time, m_fr, m_lj, ur, m_cur);
      end
      if (xfer) begin
        m_full = 1;
        m_buf = s_data;
        $display("xfer  @%0t samples=%h", $time, s_data);
      end
    end
    if (f > 0) begin
      e_fs = ((k < N / 2) == m_lj);
      if (m_lj)        e_data = bit_of(m_cur, k);
      else if (k == 0) e_data = m_prev_last;
      else             e_data = bit_of(m_cur, k - 1);
    end
    if (fall_now) begin
      fr = (f - 1) / N;
      if (m_lj)        obs[fr % 4][N - 1 - k] = dac_data;
      else if (k > 0)  obs[fr % 4][N - k] = dac_data;
      else if (fr > 0) obs[(fr - 1) % 4][0] = dac_data;
    end
    chk("pins{rdy,fst,ur,cnt,bck,fs,data}",
        {s_ready, frame_start, underrun, underrun_cnt, dac_bck, dac_fs, dac_data},
        {!m_full, ld, ur, CNT_W'(m_cnt), 1'(tog % 2), e_fs, e_data});
  endtask

  initial begin
    int n, fr0;

    tbl[0].data = {24'hABCDEF, 24'h000000, 24'h7FFFFF, 24'h800001};
    tbl[0].lj   = 1'b0;
    tbl[0].exp  = 128'h80000100_7FFFFF00_00000000_ABCDEF00;
    tbl[1].data = {24'h800000, 24'h000001, 24'hFEDCBA, 24'h123456};
    tbl[1].lj   = 1'b1;
    tbl[1].exp  = 128'h12345600_FEDCBA00_00000100_80000000;
    tbl[2].data = {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    tbl[2].lj   = 1'b0;
    tbl[2].exp  = 128'hFFFFFF00_FFFFFF00_FFFFFF00_FFFFFF00;

    rst = 1; en = 0; mode_lj = 0; s_valid = 0; s_data = '0;
    m_full = 0; m_buf = '0; m_hold = '0; m_cur = '0; m_lj = 0;
    m_prev_last = 0; m_cnt = 0; m_t = -1; m_fr = 0;
    step(); step();
    chk("reset_s_ready", s_ready, 1);
    chk("reset_pins", {dac_bck, dac_fs, dac_data, frame_start, underrun}, 0);
    chk("reset_cnt", underrun_cnt, 0);
    rst = 0; en = 1;

    // Directed frames: captured serial stream against hand-written constants.
    for (int i = 0; i < 3; i++) begin
      mode_lj = tbl[i].lj;
      n = 0;
      while (m_full && n < 2 * FRAME_CLK) begin step(); n++; end
      chk("tbl_wait_ready", n < 2 * FRAME_CLK, 1);
      s_valid = 1; s_data = tbl[i].data;
      step();
      s_valid = 0;
      n = 0;
      while (m_full && n < 2 * FRAME_CLK) begin step(); n++; end
      chk("tbl_wait_load", n < 2 * FRAME_CLK, 1);
      fr0 = m_fr;
      for (int j = 0; j < (N + 4) * 2 * BCK_DIV; j++) step();
      chk($sformatf("tbl%0d_stream", i), obs[fr0 % 4], tbl[i].exp);
    end
    // Frames 1, 3 and 5 found the buffer empty.
    chk("cnt_after_tbl", underrun_cnt, 3);

    // Transfer in the very clock of a load with the buffer empty.
    n = 0;
    while (!next_is_load() && n < 2 * FRAME_CLK) begin step(); n++; end
    chk("t5_wait_edge", n < 2 * FRAME_CLK, 1);
    s_valid = 1; rand_data();
    step();
    s_valid = 0;
    chk("t5_underrun", underrun, 1);
    chk("t5_frame_start", frame_start, 1);
    chk("t5_s_ready", s_ready, 0);
    n = 0;
    do begin step(); n++; end while (!frame_start && n < 2 * FRAME_CLK);
    chk("t5_next_load_seen", frame_start, 1);
    chk("t5_next_no_underrun", underrun, 0);
    chk("t5_next_s_ready", s_ready, 1);

    // Enable dropped mid-frame with a frame buffered.
    s_valid = 1; rand_data();
    step();
    s_valid = 0;
    for (int j = 0; j < 40; j++) step();
    en = 0;
    step();
    chk("t6_pins_off", {dac_bck, dac_fs, dac_data}, 0);
    chk("t6_buffer_kept", s_ready, 0);
    for (int j = 0; j < 10; j++) step();
    en = 1;
    n = 0;
    do begin step(); n++; end while (!frame_start && n < 4 * BCK_DIV + 4);
    chk("t6_first_fall_load", frame_start, 1);
    chk("t6_no_underrun", underrun, 0);
    chk("t6_buffer_loaded", s_ready, 1);
    for (int j = 0; j < 200; j++) step();
    rst = 1;
    step();
    chk("t6_rst_s_ready", s_ready, 1);
    chk("t6_rst_pins", {dac_bck, dac_fs, dac_data, frame_start, underrun}, 0);
    chk("t6_rst_cnt", underrun_cnt, 0);
    rst = 0;

    // Random traffic: bursty pushes, mode flips, occasional enable drops.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 2999) == 0) en = 0;
      else if (!en && $urandom_range(0, 15) == 0) en = 1;
      if ($urandom_range(0, 299) == 0) mode_lj = ~mode_lj;
      s_valid = (((i / 4096) % 2) == 0) && ($urandom_range(0, 99) < 3);
      rand_data();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
